// File: rtl/fpu_norm_lshift_pipe_pkg.sv
// Shared widths, beat type and shift helper for the FPU normalizing left-shifter.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   MANT_W / LZC_W / EXP_W / TAG_W : datapath widths (2**LZC_W >= MANT_W)
//   CRS_GRAN / FINE_W / CRS_W      : coarse/fine split of the shift amount
//   norm_beat_t                    : one input beat {mant, exp, lz, zero, tag}
//   sat_shift()                    : shift amount that saturates illegal counts
package fpu_norm_pkg;

    localparam int MANT_W = 64;
    localparam int LZC_W  = 6;
    localparam int EXP_W  = 12;
    localparam int TAG_W  = 4;

    // Coarse stage shifts in whole bytes, fine stage covers the remaining 0..7.
    localparam int CRS_GRAN = 8;
    localparam int FINE_W   = $clog2(CRS_GRAN);
    localparam int CRS_W    = LZC_W - FINE_W;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic [LZC_W-1:0]  lz;
        logic              zero;
        logic [TAG_W-1:0]  tag;
    } norm_beat_t;

    // A lead-0 count at or beyond the mantissa width cannot come from a real
    // non-zero mantissa. Pushing it to all-ones guarantees the barrel shift
    // runs every bit off the top, so the mantissa ends up zero.
    function automatic logic [LZC_W-1:0] sat_shift(input logic [LZC_W-1:0] lz);
        if (int'(lz) >= MANT_W) begin
            return '1;
        end
        return lz;
    endfunction

endpackage

// File: rtl/fpu_norm_lshift_pipe_if.sv
// Handshake bundle between the add/mul datapath, the normalizer and the rounder.
// Latency: n/a (interface only).
// Backpressure: valid/ready on both the input and output channels.
//
// master : the producer/consumer environment (drives in_*, out_rdy)
// slave  : the normalizer (drives in_rdy, out_*)
interface fpu_norm_lshift_pipe_if;
    import fpu_norm_pkg::*;

    logic              in_vld;
    logic              in_rdy;
    logic [MANT_W-1:0] in_mant;
    logic [LZC_W-1:0]  in_lz;
    logic              in_zero;
    logic [EXP_W-1:0]  in_exp;
    logic [TAG_W-1:0]  in_tag;

    logic              out_vld;
    logic              out_rdy;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_uf;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_vld, in_mant, in_lz, in_zero, in_exp, in_tag, out_rdy,
        input  in_rdy, out_vld, out_mant, out_exp, out_zero, out_uf, out_tag
    );

    modport slave (
        input  in_vld, in_mant, in_lz, in_zero, in_exp, in_tag, out_rdy,
        output in_rdy, out_vld, out_mant, out_exp, out_zero, out_uf, out_tag
    );

endinterface

// File: rtl/fpu_norm_lshift_pipe_shift_stage.sv
// Registered barrel left-shift by i_sel*SHIFT_GRAN bits, loaded when i_en is high.
// Latency: 1 cycle.
// Backpressure: none internally; the caller gates i_en, and the register holds while i_en is low.
//
// Ports:
//   rclk, arst_l : clock, asynchronous active-low reset (register clears to 0)
//   i_en         : load enable
//   i_dat/i_sel  : data to shift, shift amount in units of SHIFT_GRAN
//   o_dat        : registered shifted data
module fpu_norm_shift_stage #(
    parameter int W          = 64,
    parameter int SEL_W      = 3,
    parameter int SHIFT_GRAN = 1
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             i_en,
    input  logic [W-1:0]     i_dat,
    input  logic [SEL_W-1:0] i_sel,
    output logic [W-1:0]     o_dat
);

    logic [W-1:0] w_shifted;
    logic [W-1:0] r_dat;

    // Shifts of W or more clear the word, which is what the saturated
    // illegal-count case relies on.
    always_comb begin
        w_shifted = i_dat << (32'(i_sel) * SHIFT_GRAN);
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_dat <= '0;
        end else if (i_en) begin
            r_dat <= w_shifted;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/fpu_norm_lshift_pipe.sv
// Normalizing left-shifter: shifts the mantissa by its lead-0 count and lowers the exponent to match.
// Latency: 2 cycles from accept to out_vld; one beat per cycle when unstalled.
// Backpressure: each stage holds while its successor is full and stalled; in_rdy drops only when both stages are full.
//
// Ports: rclk (clock), arst_l (async active-low reset), bus (fpu_norm_lshift_pipe_if.slave):
//   in_vld/in_rdy, in_mant, in_lz, in_zero, in_exp, in_tag  -> beat from the datapath
//   out_vld/out_rdy, out_mant, out_exp, out_zero, out_uf, out_tag -> beat to the rounder
// Build option FPU_NORM_DENORM_EN: caps the shift so the exponent stops at the denormal
// boundary (out_exp=0, out_uf=1 when capped). Undefined: full shift, exponent wraps and out_uf flags the wrap.
module fpu_norm_lshift_pipe
    import fpu_norm_pkg::*;
(
    input logic                   rclk,
    input logic                   arst_l,
    fpu_norm_lshift_pipe_if.slave bus
);

    // ---------------------------------------------------------------
    // Stage enables
    // ---------------------------------------------------------------
    logic r_s1_vld;
    logic r_s2_vld;
    logic w_en1;
    logic w_en2;
    logic w_ld1;
    logic w_ld2;

    assign w_en2 = !r_s2_vld || bus.out_rdy;
    assign w_en1 = !r_s1_vld || w_en2;
    assign w_ld1 = w_en1 && bus.in_vld;
    assign w_ld2 = w_en2 && r_s1_vld;

    assign bus.in_rdy = w_en1;

    // ---------------------------------------------------------------
    // Stage 1: shift amount, coarse byte shift, sideband capture
    // ---------------------------------------------------------------
    norm_beat_t        w_in_beat;
    logic [LZC_W-1:0]  w_sh;
    logic [LZC_W-1:0]  w_dec;
    logic              w_lim;

    always_comb begin
        w_in_beat.mant = bus.in_zero ? '0 : bus.in_mant;
        w_in_beat.exp  = bus.in_exp;
        w_in_beat.lz   = bus.in_lz;
        w_in_beat.zero = bus.in_zero;
        w_in_beat.tag  = bus.in_tag;
    end

    // w_sh drives the mantissa shift, w_dec is what gets taken off the
    // exponent. They differ only for the saturated illegal-count case,
    // where the exponent still follows the raw count.
    always_comb begin
        w_sh  = sat_shift(w_in_beat.lz);
        w_dec = w_in_beat.lz;
        w_lim = 1'b0;
`ifdef FPU_NORM_DENORM_EN
        // The shift may not take the exponent below 1. When the count would
        // reach or pass that point (lz >= exp, or any shift at exp == 0),
        // shift only exp-1 places and mark the result denormal.
        if ((w_in_beat.lz != '0) &&
            ({{(EXP_W-LZC_W){1'b0}}, w_in_beat.lz} >= w_in_beat.exp)) begin
            w_lim = 1'b1;
            w_sh  = (w_in_beat.exp == '0) ? '0 :
                    LZC_W'(w_in_beat.exp - EXP_W'(1));
            w_dec = w_sh;
        end
`endif
    end

    logic [MANT_W-1:0] w_m1;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [LZC_W-1:0]  r_s1_lz;
    logic [FINE_W-1:0] r_s1_fine;
    logic              r_s1_zero;
    logic              r_s1_lim;
    logic [TAG_W-1:0]  r_s1_tag;

    fpu_norm_shift_stage #(
        .W          (MANT_W),
        .SEL_W      (CRS_W),
        .SHIFT_GRAN (CRS_GRAN)
    ) u_coarse (
        .rclk   (rclk),
        .arst_l (arst_l),
        .i_en   (w_ld1),
        .i_dat  (w_in_beat.mant),
        .i_sel  (w_sh[LZC_W-1:FINE_W]),
        .o_dat  (w_m1)
    );

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_s1_vld  <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_lz   <= '0;
            r_s1_fine <= '0;
            r_s1_zero <= 1'b0;
            r_s1_lim  <= 1'b0;
            r_s1_tag  <= '0;
        end else begin
            if (w_en1) begin
                r_s1_vld <= bus.in_vld;
            end
            if (w_ld1) begin
                r_s1_exp  <= w_in_beat.exp;
                r_s1_lz   <= w_dec;
                r_s1_fine <= w_sh[FINE_W-1:0];
                r_s1_zero <= w_in_beat.zero;
                r_s1_lim  <= w_lim;
                r_s1_tag  <= w_in_beat.tag;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: fine bit shift and exponent subtract
    // ---------------------------------------------------------------
    logic [MANT_W-1:0] w_m2;
    logic [EXP_W:0]    w_diff;
    logic [EXP_W-1:0]  w_exp_nx;
    logic              w_uf_nx;
    logic [EXP_W-1:0]  r_s2_exp;
    logic              r_s2_zero;
    logic              r_s2_uf;
    logic [TAG_W-1:0]  r_s2_tag;

    fpu_norm_shift_stage #(
        .W          (MANT_W),
        .SEL_W      (FINE_W),
        .SHIFT_GRAN (1)
    ) u_fine (
        .rclk   (rclk),
        .arst_l (arst_l),
        .i_en   (w_ld2),
        .i_dat  (w_m1),
        .i_sel  (r_s1_fine),
        .o_dat  (w_m2)
    );

    // One extra bit on the subtract: its borrow is the underflow flag, and
    // the low EXP_W bits are the exponent modulo 2**EXP_W.
    always_comb begin
        w_diff   = {1'b0, r_s1_exp} - {{(EXP_W+1-LZC_W){1'b0}}, r_s1_lz};
        w_exp_nx = w_diff[EXP_W-1:0];
        w_uf_nx  = w_diff[EXP_W];
        if (r_s1_zero) begin
            w_exp_nx = '0;
            w_uf_nx  = 1'b0;
        end else if (r_s1_lim) begin
            w_exp_nx = '0;
            w_uf_nx  = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_s2_vld  <= 1'b0;
            r_s2_exp  <= '0;
            r_s2_zero <= 1'b0;
            r_s2_uf   <= 1'b0;
            r_s2_tag  <= '0;
        end else begin
            if (w_en2) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_ld2) begin
                r_s2_exp  <= w_exp_nx;
                r_s2_zero <= r_s1_zero;
                r_s2_uf   <= w_uf_nx;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign bus.out_vld  = r_s2_vld;
    assign bus.out_mant = w_m2;
    assign bus.out_exp  = r_s2_exp;
    assign bus.out_zero = r_s2_zero;
    assign bus.out_uf   = r_s2_uf;
    assign bus.out_tag  = r_s2_tag;

endmodule
